// File: rtl/uvmt_clk_st_period_chkr.sv
// Clock-period checker: oversamples NUM_CH clocks, measures their periods,
// checks them against expectations and cross-checks active/passive pairs.
module uvmt_clk_st_period_chkr #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 16,
    parameter int TOL      = 1,
    parameter int SETTLE_N = 2,
    parameter int LOCK_N   = 4,
    parameter int ERRC_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en_i,
    input  logic                       clr_i,
    input  logic [NUM_CH-1:0]          mon_clk_i,
    input  logic [NUM_CH*CNT_W-1:0]    exp_period_i,
    output logic [NUM_CH*CNT_W-1:0]    period_o,
    output logic [NUM_CH-1:0]          period_vld_o,
    output logic [NUM_CH-1:0]          lock_o,
    output logic [NUM_CH-1:0]          err_o,
    output logic [NUM_CH-1:0]          stuck_o,
    output logic [NUM_CH*ERRC_W-1:0]   err_cnt_o,
    output logic [NUM_CH/2-1:0]        pair_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SETTLE,
        CHECK
    } state_t;

    localparam int SW = (SETTLE_N > 0) ? $clog2(SETTLE_N + 1) : 1;
    localparam int GW = $clog2(LOCK_N + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [ERRC_W-1:0] EC_MAX  = '1;
    localparam logic [CNT_W:0]    TOL_V   = (CNT_W + 1)'(TOL);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic              s1;
        logic              s2;
        logic              s3;
        logic              rise;
        state_t            st_q;
        state_t            st_d;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic [CNT_W-1:0]  per_q;
        logic [CNT_W-1:0]  per_d;
        logic [CNT_W-1:0]  meas;
        logic [CNT_W-1:0]  exp_p;
        logic [SW-1:0]     set_q;
        logic [SW-1:0]     set_d;
        logic [GW-1:0]     good_q;
        logic [GW-1:0]     good_d;
        logic              lock_q;
        logic              lock_d;
        logic              vld_q;
        logic              vld_d;
        logic              err_q;
        logic              err_d;
        logic              stk_q;
        logic              stk_d;
        logic [ERRC_W-1:0] ec_q;
        logic [ERRC_W-1:0] ec_d;
        logic              err_ev;
        logic              to_ev;
        logic              tmo;
        logic              in_tol;
        logic [CNT_W:0]    diff;
        logic [CNT_W:0]    adiff;

        assign exp_p  = exp_period_i[i*CNT_W +: CNT_W];
        assign rise   = s2 & ~s3;
        assign meas   = cnt_q + CNT_W'(1);
        assign diff   = {1'b0, meas} - {1'b0, exp_p};
        assign adiff  = diff[CNT_W] ? -diff : diff;
        assign in_tol = (adiff <= TOL_V);
        // Fires only on the step into saturation, so once per stall
        assign tmo    = (st_q != IDLE) && !rise
                        && (cnt_q == CNT_MAX - CNT_W'(1));

        // Two-flop synchronizer plus history flop for edge detection
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
                s3 <= 1'b0;
            end else begin
                s1 <= mon_clk_i[i];
                s2 <= s1;
                s3 <= s2;
            end
        end

        // Next-state: FSM, period counter, checks and sticky status
        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            set_d  = set_q;
            good_d = good_q;
            lock_d = lock_q;
            per_d  = per_q;
            vld_d  = 1'b0;
            err_d  = err_q;
            stk_d  = stk_q;
            ec_d   = ec_q;
            err_ev = 1'b0;
            to_ev  = 1'b0;
            if (!en_i) begin
                st_d   = IDLE;
                cnt_d  = '0;
                set_d  = '0;
                good_d = '0;
                lock_d = 1'b0;
            end else if (st_q == IDLE) begin
                cnt_d = '0;
                st_d  = WAIT;
            end else begin
                if (rise) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (tmo) begin
                    to_ev  = 1'b1;
                    err_ev = 1'b1;
                    lock_d = 1'b0;
                    good_d = '0;
                    st_d   = WAIT;
                end else if (rise) begin
                    unique case (st_q)
                        WAIT: begin
                            set_d = '0;
                            st_d  = (SETTLE_N == 0) ? CHECK : SETTLE;
                        end
                        SETTLE: begin
                            set_d = set_q + SW'(1);
                            if (set_q == SW'(SETTLE_N - 1)) begin
                                st_d = CHECK;
                            end
                        end
                        CHECK: begin
                            per_d = meas;
                            vld_d = 1'b1;
                            if (in_tol) begin
                                if (good_q != GW'(LOCK_N)) begin
                                    good_d = good_q + GW'(1);
                                end
                                if (good_q >= GW'(LOCK_N - 1)) begin
                                    lock_d = 1'b1;
                                end
                            end else begin
                                good_d = '0;
                                lock_d = 1'b0;
                                err_ev = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            if (clr_i) begin
                err_d = 1'b0;
                stk_d = 1'b0;
                ec_d  = '0;
            end
            if (to_ev) begin
                stk_d = 1'b1;
            end
            // A same-cycle error outranks the clear
            if (err_ev) begin
                err_d = 1'b1;
                if (clr_i) begin
                    ec_d = ERRC_W'(1);
                end else if (ec_q != EC_MAX) begin
                    ec_d = ec_q + ERRC_W'(1);
                end
            end
        end

        // Per-channel state register
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                set_q  <= '0;
                good_q <= '0;
                lock_q <= 1'b0;
                per_q  <= '0;
                vld_q  <= 1'b0;
                err_q  <= 1'b0;
                stk_q  <= 1'b0;
                ec_q   <= '0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                set_q  <= set_d;
                good_q <= good_d;
                lock_q <= lock_d;
                per_q  <= per_d;
                vld_q  <= vld_d;
                err_q  <= err_d;
                stk_q  <= stk_d;
                ec_q   <= ec_d;
            end
        end

        assign period_o[i*CNT_W +: CNT_W]   = per_q;
        assign period_vld_o[i]              = vld_q;
        assign lock_o[i]                    = lock_q;
        assign err_o[i]                     = err_q;
        assign stuck_o[i]                   = stk_q;
        assign err_cnt_o[i*ERRC_W +: ERRC_W] = ec_q;
    end

    for (genvar j = 0; j < NUM_CH / 2; j++) begin : g_pair
        logic [CNT_W-1:0] pa;
        logic [CNT_W-1:0] pb;
        logic [CNT_W:0]   pd;
        logic [CNT_W:0]   pad;
        logic             hit;
        logic             mism;
        logic             pe_q;

        assign pa   = period_o[(2*j)*CNT_W +: CNT_W];
        assign pb   = period_o[(2*j+1)*CNT_W +: CNT_W];
        assign pd   = {1'b0, pa} - {1'b0, pb};
        assign pad  = pd[CNT_W] ? -pd : pd;
        assign hit  = (period_vld_o[2*j] | period_vld_o[2*j+1])
                      & lock_o[2*j] & lock_o[2*j+1];
        assign mism = hit && (pad > TOL_V);

        // Sticky pair disagreement, set wins over clear
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pe_q <= 1'b0;
            end else if (mism) begin
                pe_q <= 1'b1;
            end else if (clr_i) begin
                pe_q <= 1'b0;
            end
        end

        assign pair_err_o[j] = pe_q;
    end

endmodule

// File: tb/tb_uvmt_clk_st_period_chkr.sv
// Bench for uvmt_clk_st_period_chkr: clk-aligned monitored clocks,
// expected period reports queued per channel and checked by a monitor.
module tb_uvmt_clk_st_period_chkr;

    localparam int NCH = 2;
    localparam int CW  = 6;
    localparam int EW  = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              en = 1'b0;
    logic              clr = 1'b0;
    logic [NCH-1:0]    mon = '0;
    logic [NCH*CW-1:0] expp;
    logic [NCH*CW-1:0] period_o;
    logic [NCH-1:0]    vld_o;
    logic [NCH-1:0]    lock_o;
    logic [NCH-1:0]    err_o;
    logic [NCH-1:0]    stuck_o;
    logic [NCH*EW-1:0] ec_o;
    logic [NCH/2-1:0]  pair_o;

    typedef struct packed {
        logic [CW-1:0] per;
        logic          lock;
        logic          err;
        logic [EW-1:0] ec;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   gq0[$];
    int   gq1[$];
    int   gph[NCH];
    int   gp[NCH];
    bit   grun[NCH];
    int   last_vld[NCH];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    uvmt_clk_st_period_chkr #(
        .NUM_CH(NCH), .CNT_W(CW), .TOL(1),
        .SETTLE_N(2), .LOCK_N(4), .ERRC_W(EW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .en_i(en),
        .clr_i(clr),
        .mon_clk_i(mon),
        .exp_period_i(expp),
        .period_o(period_o),
        .period_vld_o(vld_o),
        .lock_o(lock_o),
        .err_o(err_o),
        .stuck_o(stuck_o),
        .err_cnt_o(ec_o),
        .pair_err_o(pair_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Each queued period starts with a rising edge; empty queue holds low
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (gph[c] == 0) begin
                grun[c] = 1'b0;
                if (c == 0 && gq0.size() > 0) begin
                    gp[c] = gq0.pop_front();
                    grun[c] = 1'b1;
                end else if (c == 1 && gq1.size() > 0) begin
                    gp[c] = gq1.pop_front();
                    grun[c] = 1'b1;
                end
            end
            if (grun[c]) begin
                mon[c] = (gph[c] < gp[c] / 2);
                gph[c] = (gph[c] + 1 == gp[c]) ? 0 : gph[c] + 1;
            end else begin
                mon[c] = 1'b0;
            end
        end
    end

    // Monitor: every period report is matched against the scoreboard
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        bit   have;
        for (int c = 0; c < NCH; c++) begin
            if (reset_n && vld_o[c]) begin
                act.per  = period_o[c*CW +: CW];
                act.lock = lock_o[c];
                act.err  = err_o[c];
                act.ec   = ec_o[c*EW +: EW];
                last_vld[c] = cyc;
                checks++;
                have = 1'b0;
                e = '0;
                if (c == 0 && sb0.size() > 0) begin
                    e = sb0.pop_front();
                    have = 1'b1;
                end else if (c == 1 && sb1.size() > 0) begin
                    e = sb1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    errors++;
                    $display("FAIL vld_ch%0d unexpected: got per=%0d lock=%0d err=%0d cnt=%0d",
                             c, act.per, act.lock, act.err, act.ec);
                end else if (act !== e) begin
                    errors++;
                    $display("FAIL vld_ch%0d: got per=%0d lock=%0d err=%0d cnt=%0d, expected per=%0d lock=%0d err=%0d cnt=%0d",
                             c, act.per, act.lock, act.err, act.ec,
                             e.per, e.lock, e.err, e.ec);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic gen(input int ch, input int n, input int per);
        repeat (n) begin
            if (ch == 0) gq0.push_back(per);
            else gq1.push_back(per);
        end
    endtask

    task automatic ex(input int ch, input int n, input int per,
                      input bit lk, input bit er, input int ec);
        exp_t e;
        e.per  = CW'(per);
        e.lock = lk;
        e.err  = er;
        e.ec   = EW'(ec);
        repeat (n) begin
            if (ch == 0) sb0.push_back(e);
            else sb1.push_back(e);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((sb0.size() > 0 || sb1.size() > 0 || gq0.size() > 0
                || gq1.size() > 0 || grun[0] || grun[1]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s drain: timed out with %0d/%0d reports pending",
                     name, sb0.size(), sb1.size());
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        expp = {6'd10, 6'd10};

        // Reset held while clocks toggle, released with en low
        repeat (3) @(negedge clk);
        gen(0, 6, 10);
        gen(1, 6, 10);
        repeat (20) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_period", period_o, 0);
        chk("rst_vld", vld_o, 0);
        chk("rst_lock", lock_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_stuck", stuck_o, 0);
        chk("rst_errcnt", ec_o, 0);
        chk("rst_pair", pair_o, 0);
        drain("idle", 200);
        repeat (5) @(negedge clk);
        chk("idle_period", period_o, 0);
        chk("idle_lock", lock_o, 0);
        chk("idle_err", err_o, 0);

        // Nominal lock, frequency step and return on ch0; ch1 steady
        en = 1'b1;
        gen(0, 10, 10);
        gen(0, 1, 14);
        gen(0, 5, 10);
        gen(1, 10, 10);
        ex(0, 3, 10, 0, 0, 0);
        ex(0, 5, 10, 1, 0, 0);
        ex(0, 1, 14, 0, 1, 1);
        ex(0, 3, 10, 0, 1, 1);
        ex(0, 1, 10, 1, 1, 1);
        ex(1, 3, 10, 0, 0, 0);
        ex(1, 4, 10, 1, 0, 0);
        drain("step", 400);

        // ch0 now stalls low: timeout 63 cycles after its last report
        n = 0;
        while (!stuck_o[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stuck_seen", stuck_o[0], 1);
        chk("stuck_delay", cyc - last_vld[0], 63);
        chk("stuck_err", err_o[0], 1);
        chk("stuck_errcnt", ec_o[EW-1:0], 2);
        chk("stuck_lock", lock_o[0], 0);

        // Resume and relock; sticky status persists until cleared
        gen(0, 8, 10);
        ex(0, 3, 10, 0, 1, 2);
        ex(0, 2, 10, 1, 1, 2);
        drain("relock", 300);
        chk("equal_pair", pair_o, 0);
        pulse_clr();
        chk("clr_err", err_o[0], 0);
        chk("clr_stuck", stuck_o[0], 0);
        chk("clr_errcnt", ec_o[EW-1:0], 0);
        chk("clr_lock_kept", lock_o[0], 1);
        en = 1'b0;
        @(negedge clk);
        chk("dis_lock", lock_o[0], 0);
        chk("dis_period_kept", period_o[CW-1:0], 10);

        // Pair disagreement: 10 vs 13, each locked to its own target
        expp = {6'd13, 6'd10};
        en = 1'b1;
        gen(0, 8, 10);
        gen(1, 8, 13);
        ex(0, 3, 10, 0, 0, 0);
        ex(0, 2, 10, 1, 0, 0);
        ex(1, 3, 13, 0, 0, 0);
        ex(1, 2, 13, 1, 0, 0);
        drain("pair", 400);
        chk("pair_set", pair_o, 1);
        chk("pair_no_err", err_o, 0);
        en = 1'b0;
        pulse_clr();
        chk("pair_clr", pair_o, 0);

        // Error counter saturation, then clear coinciding with an error
        fork
            begin
                repeat (9) @(posedge mon[0]);
                @(negedge clk);
                @(negedge clk);
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
            end
        join_none
        en = 1'b1;
        gen(0, 2, 10);
        gen(0, 6, 14);
        gen(0, 1, 10);
        ex(0, 1, 14, 0, 1, 1);
        ex(0, 1, 14, 0, 1, 2);
        ex(0, 3, 14, 0, 1, 3);
        ex(0, 1, 14, 0, 1, 1);
        drain("sat", 400);
        chk("sat_errcnt", ec_o[EW-1:0], 1);
        chk("sat_err", err_o[0], 1);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_empty", sb0.size() + sb1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
